// File: rtl/hi_lo_pkg.sv
// Shared definitions for the HI/LO register unit: micro-op encodings
// presented by execute and the multiply-handshake FSM states.
package hi_lo_pkg;

  localparam logic [2:0] OPC_NOP   = 3'd0;
  localparam logic [2:0] OPC_MULT  = 3'd1;
  localparam logic [2:0] OPC_MULTU = 3'd2;
  localparam logic [2:0] OPC_MTHI  = 3'd3;
  localparam logic [2:0] OPC_MTLO  = 3'd4;
  localparam logic [2:0] OPC_MFHI  = 3'd5;
  localparam logic [2:0] OPC_MFLO  = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/hi_lo_ctrl.sv
// HI/LO register unit between execute and the MULT block.
// Accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO, issues a one-cycle request to
// MULT, captures the product on MULT's acknowledge and stalls execute for
// any HI/LO access while a multiply is outstanding.
// Optional build macro HI_LO_BYPASS_EN: an MFHI/MFLO arriving in the ACK
// cycle is accepted and served straight from MULT_RESULT_IN.
module hi_lo_ctrl
  import hi_lo_pkg::*;
#(
  parameter int OPC_W  = 3,
  parameter int DATA_W = 32
) (
  input  logic                  CLK,
  input  logic                  RST_ASYNC_N,
  input  logic                  OP_VALID_IN,
  input  logic [OPC_W-1:0]      OP_CODE_IN,
  input  logic [DATA_W-1:0]     OP_RS_IN,
  input  logic [DATA_W-1:0]     OP_RT_IN,
  output logic                  STALL_OUT,
  output logic                  MF_VALID_OUT,
  output logic [DATA_W-1:0]     MF_DATA_OUT,
  output logic                  MULT_REQ_OUT,
  output logic                  MULT_SIGNED_OUT,
  output logic [DATA_W-1:0]     MULT_A_OUT,
  output logic [DATA_W-1:0]     MULT_B_OUT,
  input  logic                  MULT_ACK_IN,
  input  logic [2*DATA_W-1:0]   MULT_RESULT_IN,
  output logic [DATA_W-1:0]     HI_OUT,
  output logic [DATA_W-1:0]     LO_OUT
);

  state_t              r_state;
  state_t              w_next_state;
  logic [DATA_W-1:0]   r_hi;
  logic [DATA_W-1:0]   r_lo;
  logic [DATA_W-1:0]   r_mf_data;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic                r_mf_valid;
  logic                r_signed;
  logic                w_mult_req;

  logic                w_is_mult;
  logic                w_is_multu;
  logic                w_is_mthi;
  logic                w_is_mtlo;
  logic                w_is_mfhi;
  logic                w_is_mflo;
  logic                w_is_hilo;
  logic                w_ack_take;
  logic                w_bypass;
  logic                w_stall;
  logic                w_accept;
  logic [DATA_W-1:0]   w_res_hi;
  logic [DATA_W-1:0]   w_res_lo;

  assign w_is_mult  = (OP_CODE_IN == OPC_W'(OPC_MULT));
  assign w_is_multu = (OP_CODE_IN == OPC_W'(OPC_MULTU));
  assign w_is_mthi  = (OP_CODE_IN == OPC_W'(OPC_MTHI));
  assign w_is_mtlo  = (OP_CODE_IN == OPC_W'(OPC_MTLO));
  assign w_is_mfhi  = (OP_CODE_IN == OPC_W'(OPC_MFHI));
  assign w_is_mflo  = (OP_CODE_IN == OPC_W'(OPC_MFLO));
  // NOP and the reserved opcode touch nothing, so they never stall.
  assign w_is_hilo  = w_is_mult | w_is_multu | w_is_mthi | w_is_mtlo |
                      w_is_mfhi | w_is_mflo;

  assign w_res_hi   = MULT_RESULT_IN[2*DATA_W-1:DATA_W];
  assign w_res_lo   = MULT_RESULT_IN[DATA_W-1:0];

  // ACKs outside WAIT (spurious, or arriving after a reset abort) are dropped.
  assign w_ack_take = (r_state == ST_WAIT) && MULT_ACK_IN;

`ifdef HI_LO_BYPASS_EN
  assign w_bypass   = w_ack_take && (w_is_mfhi | w_is_mflo);
`else
  assign w_bypass   = 1'b0;
`endif

  assign w_stall    = OP_VALID_IN && (r_state != ST_IDLE) && w_is_hilo && !w_bypass;
  assign w_accept   = OP_VALID_IN && !w_stall;

  // FSM state register.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) r_state <= ST_IDLE;
    else              r_state <= w_next_state;
  end

  // FSM next-state: IDLE -> ISSUE on an accepted multiply, ISSUE -> WAIT, WAIT -> IDLE on ACK.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && (w_is_mult | w_is_multu)) w_next_state = ST_ISSUE;
      ST_ISSUE: w_next_state = ST_WAIT;
      ST_WAIT:  if (MULT_ACK_IN) w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM outputs: the request is asserted for the single ISSUE cycle.
  always_comb begin
    w_mult_req = 1'b0;
    if (r_state == ST_ISSUE) w_mult_req = 1'b1;
  end

  // Operand latch: rs/rt and signedness are held for the whole transaction.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
    end else if (w_accept && (w_is_mult | w_is_multu)) begin
      r_a      <= OP_RS_IN;
      r_b      <= OP_RT_IN;
      r_signed <= w_is_mult;
    end
  end

  // HI/LO: product capture on ACK; MTHI/MTLO only land when no multiply is in flight.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_ack_take) begin
      r_hi <= w_res_hi;
      r_lo <= w_res_lo;
    end else if (w_accept) begin
      if (w_is_mthi) r_hi <= OP_RS_IN;
      if (w_is_mtlo) r_lo <= OP_RS_IN;
    end
  end

  // MFHI/MFLO read port: one-cycle valid pulse; in the ACK cycle the data comes from the product.
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      r_mf_valid <= 1'b0;
      r_mf_data  <= '0;
    end else begin
      r_mf_valid <= w_accept && (w_is_mfhi | w_is_mflo);
      if (w_accept && w_is_mfhi)
        r_mf_data <= w_ack_take ? w_res_hi : r_hi;
      else if (w_accept && w_is_mflo)
        r_mf_data <= w_ack_take ? w_res_lo : r_lo;
    end
  end

  assign STALL_OUT       = w_stall;
  assign MF_VALID_OUT    = r_mf_valid;
  assign MF_DATA_OUT     = r_mf_data;
  assign MULT_REQ_OUT    = w_mult_req;
  assign MULT_SIGNED_OUT = r_signed;
  assign MULT_A_OUT      = r_a;
  assign MULT_B_OUT      = r_b;
  assign HI_OUT          = r_hi;
  assign LO_OUT          = r_lo;

endmodule
